tqvp_bus_bridge: RTL and testbench
==================================

TQVP_BUS_BRIDGE -- requirements
Module: tqvp_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum read-wait cycles before error.
REQ-002 SHALL have port clk  input  1: project clock, 64 MHz nominal.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid  input  1 and req_ready  output  1: core request handshake.
REQ-005 SHALL have ports req_addr  input  6, req_wdata  input  32, req_write  input  1, req_size  input  2 (00=8, 01=16, 10=32 bits, 11=illegal).
REQ-006 SHALL have ports rsp_valid  output  1, rsp_rdata  output  32, rsp_err  output  1: one-cycle response pulse.
REQ-007 SHALL have ports address  output  6, data_in  output  32, data_write_n  output  2, data_read_n  output  2: peripheral-side bus, same encoding as the peripheral template.
REQ-008 SHALL have ports data_out  input  32 and data_ready  input  1: peripheral read return.

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-010 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-011 On acceptance, req_addr, req_wdata, req_write and req_size SHALL be registered; later changes on req_* SHALL have no effect until the next acceptance.
REQ-012 Accepted write, legal size: WRITE SHALL last exactly one cycle, with data_write_n = req_size and data_read_n = 11; then RESP.
REQ-013 Accepted read, legal size: READ SHALL hold data_read_n = req_size and data_write_n = 11 until data_ready is sampled 1, then capture data_out and go to RESP.
REQ-014 Read data SHALL be zero-extended: size 00 keeps bits [7:0], size 01 keeps [15:0], size 10 keeps all 32.
REQ-015 If data_ready is 1 in the first READ cycle, read latency SHALL be 1 cycle; rsp_valid SHALL assert in the following cycle.
REQ-016 A READ lasting TIMEOUT_CYCLES cycles without data_ready SHALL release data_read_n to 11 and go to RESP with rsp_err=1 and rsp_rdata=32'hFFFFFFFF.
REQ-017 req_size=11 SHALL skip the bus access: go directly to RESP with rsp_err=1 and rsp_rdata=0.
REQ-018 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; rsp_rdata SHALL be 0 for writes.
REQ-019 Outside WRITE/READ, data_write_n and data_read_n SHALL be 11; address and data_in SHALL hold the last registered values.
REQ-020 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES, SHALL clear on every acceptance, and SHALL NOT wrap.
REQ-021 rsp_valid SHALL be 0 in every state other than RESP.

Reset
REQ-022 While rst_n=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, address=0, data_in=0, data_write_n=11, data_read_n=11, counter=0.
REQ-023 Reset asserted mid-READ SHALL immediately return data_read_n to 11, with no response issued.

Structure
REQ-024 A shared package SHALL hold the state enum, size encodings (SIZE_8/16/32/NONE = 00/01/10/11) and the timeout error word 32'hFFFFFFFF.
REQ-025 The zero-extension mask SHALL be one small sub-module, tqvp_size_mask; everything else SHALL be flat.

Verification
REQ-026 Write size 10, addr 0, wdata 0xDEADBEEF -> one cycle with data_write_n=10, address=0, data_in=0xDEADBEEF; next cycle rsp_valid=1, rsp_err=0.
REQ-027 Read size 00, addr 4; peripheral returns 0x12345678 with data_ready=1 immediately -> rsp_rdata=0x00000078, rsp_err=0, two cycles after acceptance.
REQ-028 Read size 01, data_ready held low 3 cycles, then high with 0xAABBCCDD -> data_read_n=01 for 4 cycles, rsp_rdata=0x0000CCDD.
REQ-029 Read with data_ready stuck at 0, TIMEOUT_CYCLES=15 -> data_read_n returns to 11 after 15 cycles; rsp_err=1, rsp_rdata=0xFFFFFFFF.
REQ-030 Request with size 11 -> no bus activity; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-031 rst_n pulsed low during READ cycle 2 -> data_read_n=11 asynchronously, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/tqvp_bus_bridge_pkg.sv
// Shared types and constants for the TQVP core-to-peripheral bus bridge.
package tqvp_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [1:0]  SIZE_8       = 2'b00;
    localparam logic [1:0]  SIZE_16      = 2'b01;
    localparam logic [1:0]  SIZE_32      = 2'b10;
    localparam logic [1:0]  SIZE_NONE    = 2'b11;

    // An access strobe of 11 means the bus is quiet.
    localparam logic [1:0]  BUS_IDLE     = 2'b11;
    localparam logic [31:0] TIMEOUT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/tqvp_size_mask.sv
// Zero-extends peripheral read data according to the access size.
module tqvp_size_mask
    import tqvp_bus_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] masked
);

    always_comb begin
        masked = data;
        case (size)
            SIZE_8:  masked = {24'h0, data[7:0]};
            SIZE_16: masked = {16'h0, data[15:0]};
            default: masked = data;
        endcase
    end

endmodule

// File: rtl/tqvp_bus_bridge.sv
// Bridges a valid/ready core request port onto the TQVP peripheral bus,
// returning a single-cycle response with error reporting and read timeout.
module tqvp_bus_bridge
    import tqvp_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state;
    state_t          next_state;
    logic [5:0]      addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic [CW-1:0]   count;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     masked_data;
    logic            accept;
    logic            timeout_hit;

    tqvp_size_mask u_size_mask (
        .size   (size_q),
        .data   (data_out),
        .masked (masked_data)
    );

    assign accept      = (state == IDLE) && req_valid;
    assign timeout_hit = (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_size == SIZE_NONE) begin
                        next_state = RESP;
                    end else if (req_write) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            WRITE:   next_state = RESP;
            READ: begin
                if (data_ready || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured only on acceptance; the response word is
    // prepared on the way into RESP so it is stable for the whole pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= BUS_IDLE;
            count   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                count   <= '0;
                rdata_q <= '0;
                err_q   <= (req_size == SIZE_NONE);
            end else if (state == READ) begin
                if (data_ready) begin
                    rdata_q <= masked_data;
                    err_q   <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q <= TIMEOUT_WORD;
                    err_q   <= 1'b1;
                end else begin
                    count   <= count + CW'(1);
                end
            end
        end
    end

    assign req_ready    = (state == IDLE);
    assign rsp_valid    = (state == RESP);
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign address      = addr_q;
    assign data_in      = wdata_q;
    assign data_write_n = (state == WRITE) ? size_q : BUS_IDLE;
    assign data_read_n  = (state == READ)  ? size_q : BUS_IDLE;

endmodule

// File: tb/tb_tqvp_bus_bridge.sv
// Directed, table-driven bench for tqvp_bus_bridge with hand-computed results
// plus hand-written reset and timeout-boundary sequences.
module tb_tqvp_bus_bridge;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [1:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int n_applied = 0;
    int n_miscompares = 0;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] periph;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    tqvp_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_write    (req_write),
        .req_size     (req_size),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One full transaction: request, per-cycle bus checks, response, return to idle.
    task automatic run_vec(input int idx, input vec_t v);
        int bus;
        if (v.size == 2'b11)   bus = 0;
        else if (v.write)      bus = 1;
        else if (v.delay >= TIMEOUT) bus = TIMEOUT;
        else                   bus = v.delay + 1;

        @(negedge clk);
        check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_write = ~v.write;
        req_size  = 2'b00;
        for (int i = 0; i < bus; i++) begin
            data_ready = (!v.write && i == v.delay);
            data_out   = (!v.write && i == v.delay) ? v.periph : 32'h5A5A_5A5A;
            check($sformatf("v%0d c%0d write_n", idx, i), 32'(data_write_n), v.write ? 32'(v.size) : 32'd3);
            check($sformatf("v%0d c%0d read_n", idx, i), 32'(data_read_n), v.write ? 32'd3 : 32'(v.size));
            check($sformatf("v%0d c%0d rsp_valid", idx, i), 32'(rsp_valid), 32'd0);
            if (i == 0) begin
                check($sformatf("v%0d address", idx), 32'(address), 32'(v.addr));
                check($sformatf("v%0d data_in", idx), data_in, v.wdata);
                check($sformatf("v%0d req_ready busy", idx), 32'(req_ready), 32'd0);
            end
            @(negedge clk);
        end
        data_ready = 1'b0;
        data_out   = 32'h5A5A_5A5A;
        check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
        check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d resp write_n", idx), 32'(data_write_n), 32'd3);
        check($sformatf("v%0d resp read_n", idx), 32'(data_read_n), 32'd3);
        check($sformatf("v%0d resp address", idx), 32'(address), 32'(v.addr));
        @(negedge clk);
        check($sformatf("v%0d rsp_valid drop", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d req_ready back", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        //                write size   addr   wdata         delay periph        exp_rdata     err
        vecs[0] = '{1'b1, 2'b10, 6'h00, 32'hDEADBEEF, 0,  32'h0,        32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 6'h04, 32'h0,        0,  32'h12345678, 32'h0000_0078, 1'b0};
        vecs[2] = '{1'b0, 2'b01, 6'h08, 32'h0,        3,  32'hAABBCCDD, 32'h0000_CCDD, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 6'h3F, 32'h11112222, 1,  32'hCAFEF00D, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b0, 2'b10, 6'h10, 32'h0,        99, 32'h0,        32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 2'b11, 6'h12, 32'h87654321, 0,  32'h0,        32'h0000_0000, 1'b1};
        vecs[6] = '{1'b0, 2'b11, 6'h13, 32'h0,        0,  32'h0,        32'h0000_0000, 1'b1};
        vecs[7] = '{1'b1, 2'b00, 6'h21, 32'h000000A5, 0,  32'h0,        32'h0000_0000, 1'b0};
        vecs[8] = '{1'b0, 2'b01, 6'h2C, 32'h0,        14, 32'hFFFF1234, 32'h0000_1234, 1'b0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 6'h15;
        req_wdata  = 32'h0BAD_0BAD;
        req_write  = 1'b0;
        req_size   = 2'b10;
        data_out   = 32'h5A5A_5A5A;
        data_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset address", 32'(address), 32'd0);
        check("reset data_in", data_in, 32'd0);
        check("reset write_n", 32'(data_write_n), 32'd3);
        check("reset read_n", 32'(data_read_n), 32'd3);
        rst_n = 1'b1;

        // Idle with no request must stay idle.
        repeat (2) @(negedge clk);
        check("idle rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during the second READ cycle drops the strobe asynchronously.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 6'h05;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid c1 read_n", 32'(data_read_n), 32'd2);
        @(negedge clk);
        check("rstmid c2 read_n", 32'(data_read_n), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid async read_n", 32'(data_read_n), 32'd3);
        check("rstmid req_ready", 32'(req_ready), 32'd1);
        check("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        data_ready = 1'b1;
        data_out   = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post-reset c%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("post-reset c%0d req_ready", i), 32'(req_ready), 32'd1);
            check($sformatf("post-reset c%0d read_n", i), 32'(data_read_n), 32'd3);
        end
        data_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
